// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Instruction fetch front end. Owns the architectural PC, issues one
//   single-beat read per instruction on a valid/ready instruction-memory bus,
//   and hands the fetched word (or a fetch fault) to decode over a
//   valid/ready handshake. Only one instruction is in flight: after handoff
//   the unit waits for the next PC (dnpc) from execute/writeback.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   dnpc, dnpc_valid  next PC from execute/writeback (accepted in WAIT_NPC)
//   araddr, arvalid,  read request channel to instruction memory
//   arready
//   rdata, rresp,     read response channel; rresp != 0 is a bus error
//   rvalid, rready
//   inst, pc, snpc    fetched word, its PC, and pc + 4
//   out_valid,        handoff to decode
//   out_ready
//   fault,            fault flag and cause (1 = misaligned PC, 2 = bus error)
//   fault_cause
//   fetch_cnt         number of completed handoffs (wraps)
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      dnpc,
  input  logic             dnpc_valid,
  output logic [31:0]      araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic [31:0]      inst,
  output logic [31:0]      pc,
  output logic [31:0]      snpc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] fetch_cnt
);

  typedef enum logic [1:0] {
    REQ      = 2'd0,
    WAIT_R   = 2'd1,
    HOLD     = 2'd2,
    WAIT_NPC = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE      = 2'd0;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'd1;
  localparam logic [1:0] CAUSE_BUS_ERROR = 2'd2;

  state_t           r_state;
  state_t           w_next_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_snpc;
  logic [31:0]      r_inst;
  logic             r_fault;
  logic [1:0]       r_fault_cause;
  logic [CNT_W-1:0] r_fetch_cnt;

  logic             w_misaligned;
  logic             w_arvalid;
  logic             w_rready;
  logic             w_out_valid;

  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // Next-state and handshake outputs. Outputs are decoded from the state so
  // that a dnpc accepted at T shows arvalid at T+1. They are forced low while
  // rst is high so the bus sees an idle unit throughout reset.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_next_state = r_state;
    w_arvalid    = 1'b0;
    w_rready     = 1'b0;
    w_out_valid  = 1'b0;

    unique case (r_state)
      REQ: begin
        if (w_misaligned) begin
          // Misaligned PC never reaches the bus; fault goes straight to decode.
          w_next_state = HOLD;
        end else begin
          w_arvalid = 1'b1;
          if (arready) w_next_state = WAIT_R;
        end
      end
      WAIT_R: begin
        w_rready = 1'b1;
        if (rvalid) w_next_state = HOLD;
      end
      HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) w_next_state = WAIT_NPC;
      end
      WAIT_NPC: begin
        if (dnpc_valid) w_next_state = REQ;
      end
      default: w_next_state = REQ;
    endcase

    if (rst) begin
      w_arvalid   = 1'b0;
      w_rready    = 1'b0;
      w_out_valid = 1'b0;
    end
  end

  // State register and datapath. Payload registers only change outside HOLD,
  // so inst/pc/snpc/fault stay stable for the whole handoff.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_snpc        <= RESET_PC + 32'd4;
      r_inst        <= 32'd0;
      r_fault       <= 1'b0;
      r_fault_cause <= CAUSE_NONE;
      r_fetch_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      unique case (r_state)
        REQ: begin
          if (w_misaligned) begin
            r_inst        <= 32'd0;
            r_fault       <= 1'b1;
            r_fault_cause <= CAUSE_MISALIGN;
          end
        end
        WAIT_R: begin
          if (rvalid) begin
            r_inst        <= rdata;
            r_fault       <= (rresp != 2'b00);
            r_fault_cause <= (rresp != 2'b00) ? CAUSE_BUS_ERROR : CAUSE_NONE;
          end
        end
        HOLD: begin
          if (out_ready) r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
        end
        WAIT_NPC: begin
          if (dnpc_valid) begin
            r_pc   <= dnpc;
            r_snpc <= dnpc + 32'd4;
          end
        end
        default: ;
      endcase
    end
  end

  // The request address is the PC register itself, which cannot change while
  // a request is pending, so araddr is inherently stable under backpressure.
  assign araddr      = r_pc;
  assign arvalid     = w_arvalid;
  assign rready      = w_rready;
  assign inst        = r_inst;
  assign pc          = r_pc;
  assign snpc        = r_snpc;
  assign out_valid   = w_out_valid;
  assign fault       = r_fault;
  assign fault_cause = r_fault_cause;
  assign fetch_cnt   = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Scoreboard bench for inst_fetch_unit. The stimulus process plays both the
//   instruction memory and the execute stage; whenever it commits to a
//   request address or to a response it pushes the expected bus address and
//   the expected decode payload into queues. A negedge monitor pops and
//   compares whenever the DUT presents arvalid or out_valid.
// ---------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam int          CNT_W    = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      dnpc;
  logic             dnpc_valid;
  logic [31:0]      araddr;
  logic             arvalid;
  logic             arready;
  logic [31:0]      rdata;
  logic [1:0]       rresp;
  logic             rvalid;
  logic             rready;
  logic [31:0]      inst;
  logic [31:0]      pc;
  logic [31:0]      snpc;
  logic             out_valid;
  logic             out_ready;
  logic             fault;
  logic [1:0]       fault_cause;
  logic [CNT_W-1:0] fetch_cnt;

  inst_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .dnpc        (dnpc),
    .dnpc_valid  (dnpc_valid),
    .araddr      (araddr),
    .arvalid     (arvalid),
    .arready     (arready),
    .rdata       (rdata),
    .rresp       (rresp),
    .rvalid      (rvalid),
    .rready      (rready),
    .inst        (inst),
    .pc          (pc),
    .snpc        (snpc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fault       (fault),
    .fault_cause (fault_cause),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] snpc;
    logic [31:0] inst;
    logic        fault;
    logic [1:0]  cause;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] exp_ar_q[$];

  int total = 0;
  int bad   = 0;

  // Reference state: the architectural PC and number of completed handoffs.
  logic [31:0] m_pc;
  logic [31:0] m_cnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (arvalid) begin
        if (exp_ar_q.size() == 0) begin
          check("unexpected_arvalid", arvalid, 64'd0);
        end else begin
          check("araddr", araddr, exp_ar_q[0]);
          if (arready) void'(exp_ar_q.pop_front());
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", out_valid, 64'd0);
        end else begin
          check("out_pc",    pc,          exp_q[0].pc);
          check("out_snpc",  snpc,        exp_q[0].snpc);
          check("out_inst",  inst,        exp_q[0].inst);
          check("out_fault", fault,       exp_q[0].fault);
          check("out_cause", fault_cause, exp_q[0].cause);
          check("out_cnt",   fetch_cnt,   exp_q[0].cnt);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Runs one fetch starting with the DUT in REQ at m_pc, through handoff.
  task automatic run_fetch(input int ar_dly, input int r_dly, input logic [1:0] resp,
                           input logic [31:0] data, input int out_dly,
                           input bit stray, input bit stale);
    exp_t e;
    e.pc   = m_pc;
    e.snpc = m_pc + 32'd4;
    e.cnt  = m_cnt;
    out_ready = (out_dly == 0);
    if (m_pc[1:0] != 2'b00) begin
      e.inst  = 32'd0;
      e.fault = 1'b1;
      e.cause = 2'd1;
      exp_q.push_back(e);
      tick();
      check("misalign_out_valid", out_valid, 64'd1);
    end else begin
      exp_ar_q.push_back(m_pc);
      for (int i = 0; i < ar_dly; i++) begin
        arready = 1'b0;
        // Responses outside WAIT_R must be ignored.
        rvalid  = (stale && i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        rdata   = $urandom;
        rresp   = 2'($urandom_range(0, 3));
        tick();
      end
      rvalid  = 1'b0;
      arready = 1'b1;
      tick();
      arready = 1'b0;
      check("rready_after_accept", rready, 64'd1);
      check("arvalid_after_accept", arvalid, 64'd0);
      for (int i = 0; i < r_dly; i++) begin
        if (stray && i == 0) begin
          dnpc = $urandom; dnpc_valid = 1'b1;
        end
        tick();
        dnpc_valid = 1'b0;
      end
      e.inst  = data;
      e.fault = (resp != 2'b00);
      e.cause = (resp != 2'b00) ? 2'd2 : 2'd0;
      exp_q.push_back(e);
      rdata  = data;
      rresp  = resp;
      rvalid = 1'b1;
      tick();
      rvalid = 1'b0;
      rdata  = $urandom;
      check("out_valid_after_r", out_valid, 64'd1);
    end
    for (int i = 0; i < out_dly; i++) begin
      if (stray && i == 0) begin
        dnpc = $urandom; dnpc_valid = 1'b1;
      end
      tick();
      dnpc_valid = 1'b0;
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    m_cnt = m_cnt + 32'd1;
    check("fetch_cnt_after_handoff", fetch_cnt, m_cnt);
    check("out_valid_drop", out_valid, 64'd0);
    check("pc_after_handoff", pc, m_pc);
  endtask

  // DUT is in WAIT_NPC; deliver the next PC after `gap` idle cycles.
  task automatic issue_dnpc(input logic [31:0] addr, input int gap);
    for (int i = 0; i < gap; i++) begin
      tick();
      check("idle_arvalid", arvalid, 64'd0);
    end
    dnpc       = addr;
    dnpc_valid = 1'b1;
    tick();
    dnpc_valid = 1'b0;
    dnpc       = $urandom;
    m_pc       = addr;
    check("arvalid_after_dnpc", arvalid, {63'd0, addr[1:0] == 2'b00});
  endtask

  initial begin
    rst = 1'b1; dnpc = '0; dnpc_valid = 1'b0; arready = 1'b0;
    rdata = '0; rresp = '0; rvalid = 1'b0; out_ready = 1'b0;
    m_pc = RESET_PC; m_cnt = 32'd0;

    // Reset values.
    tick(); tick();
    check("rst_pc", pc, RESET_PC);
    check("rst_snpc", snpc, RESET_PC + 32'd4);
    check("rst_arvalid", arvalid, 64'd0);
    check("rst_rready", rready, 64'd0);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_inst", inst, 64'd0);
    check("rst_fault", fault, 64'd0);
    check("rst_cause", fault_cause, 64'd0);
    check("rst_cnt", fetch_cnt, 64'd0);
    rst = 1'b0;

    // Nominal fetch with minimum-latency bus.
    run_fetch(0, 2, 2'b00, 32'h0010_0093, 0, 1'b0, 1'b0);
    // Backpressure on both bus request and decode.
    issue_dnpc(32'h8000_0004, 0);
    run_fetch(3, 1, 2'b00, 32'h0020_0113, 4, 1'b0, 1'b0);
    // Misaligned next PC.
    issue_dnpc(32'h8000_0006, 1);
    run_fetch(0, 0, 2'b00, 32'h0, 2, 1'b0, 1'b0);
    // Bus error, then a clean fetch.
    issue_dnpc(32'h8000_0008, 0);
    run_fetch(0, 0, 2'b10, 32'hDEAD_BEEF, 0, 1'b0, 1'b0);
    issue_dnpc(32'h8000_0010, 0);
    run_fetch(1, 0, 2'b00, 32'h0030_0193, 1, 1'b0, 1'b0);

    // Reset while waiting for the read response.
    issue_dnpc(32'h8000_0014, 0);
    exp_ar_q.push_back(32'h8000_0014);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check("rready_before_reset", rready, 64'd1);
    rst = 1'b1;
    tick(); tick();
    check("midrst_pc", pc, RESET_PC);
    check("midrst_cnt", fetch_cnt, 64'd0);
    check("midrst_rready", rready, 64'd0);
    m_pc = RESET_PC; m_cnt = 32'd0;
    rst = 1'b0;
    // Stale rvalid in the first cycle after release must be ignored.
    run_fetch(2, 1, 2'b00, 32'h0040_0213, 3, 1'b1, 1'b1);

    // Top-of-memory PC: snpc wraps to zero.
    issue_dnpc(32'hFFFF_FFFC, 0);
    run_fetch(0, 1, 2'b00, 32'h0050_0293, 0, 1'b0, 1'b0);

    // Randomized fetches.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      logic [1:0]  rs;
      a  = $urandom;
      if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
      rs = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      issue_dnpc(a, $urandom_range(0, 2));
      run_fetch($urandom_range(0, 3), $urandom_range(0, 3), rs, $urandom,
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    tick();
    check("sb_out_drained", exp_q.size(), 64'd0);
    check("sb_ar_drained", exp_ar_q.size(), 64'd0);
    check("final_cnt", fetch_cnt, m_cnt);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1);
  end

endmodule
